// File: rtl/cmn_wb_arbiter_pkg.sv
// Shared types and constants for the writeback merge stage and its round-robin arbiter.
// No logic. Latency and backpressure do not apply.
package cmn_wb_pkg;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_0    = 2'd1,
    GRANT_1    = 2'd2
  } grant_e;

  // in1 is treated as the previous winner, so in0 wins the first conflict after reset.
  localparam grant_e LAST_GRANT_RST = GRANT_1;
  localparam int     ZERO_REG_ADDR  = 0;

endpackage

// File: rtl/cmn_wb_arbiter_if.sv
// Bundle of writeback producer, regfile write, forwarding and stall-count signals.
// slave is the merge stage. master is the producer/regfile/read-port side.
interface cmn_wb_arbiter_if #(
  parameter int p_data_nbits = 32,
  parameter int p_addr_nbits = 5,
  parameter int p_cnt_nbits  = 16
);
  logic                    in0_val;
  logic                    in0_rdy;
  logic [p_addr_nbits-1:0] in0_addr;
  logic [p_data_nbits-1:0] in0_data;
  logic                    in1_val;
  logic                    in1_rdy;
  logic [p_addr_nbits-1:0] in1_addr;
  logic [p_data_nbits-1:0] in1_data;
  logic                    wr_en;
  logic [p_addr_nbits-1:0] wr_addr;
  logic [p_data_nbits-1:0] wr_data;
  logic [p_addr_nbits-1:0] byp_addr0;
  logic                    byp_hit0;
  logic [p_data_nbits-1:0] byp_data0;
  logic [p_addr_nbits-1:0] byp_addr1;
  logic                    byp_hit1;
  logic [p_data_nbits-1:0] byp_data1;
  logic [p_cnt_nbits-1:0]  stall_count;

  modport slave (
    input  in0_val, in0_addr, in0_data, in1_val, in1_addr, in1_data, byp_addr0, byp_addr1,
    output in0_rdy, in1_rdy, wr_en, wr_addr, wr_data, byp_hit0, byp_data0, byp_hit1,
           byp_data1, stall_count
  );

  modport master (
    output in0_val, in0_addr, in0_data, in1_val, in1_addr, in1_data, byp_addr0, byp_addr1,
    input  in0_rdy, in1_rdy, wr_en, wr_addr, wr_data, byp_hit0, byp_data0, byp_hit1,
           byp_data1, stall_count
  );
endinterface

// File: rtl/cmn_wb_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grant is combinational, and the last winner is registered on each grant.
// A request is granted only while en=1 and reset is released. The losing request waits.
module cmn_rr_arb2
  import cmn_wb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  grant_e last_grant_q, last_grant_d;
  grant_e sel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= LAST_GRANT_RST;
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    sel          = GRANT_NONE;
    last_grant_d = last_grant_q;
    if (reset && en) begin
      case (req)
        2'b01:   sel = GRANT_0;
        2'b10:   sel = GRANT_1;
        2'b11:   sel = (last_grant_q == GRANT_0) ? GRANT_1 : GRANT_0;
        default: sel = GRANT_NONE;
      endcase
    end
    if (sel != GRANT_NONE) last_grant_d = sel;
  end

  assign gnt = {sel == GRANT_1, sel == GRANT_0};

endmodule

// File: rtl/cmn_wb_arbiter.sv
// Merges two writeback producers onto one regfile write port. The write is registered for 1 cycle and forwarded to two read ports.
// One input is accepted per cycle. The conflict loser is held off, and each such cycle counts as a stall.
module cmn_wb_arbiter
  import cmn_wb_pkg::*;
#(
  parameter int p_data_nbits = 32,
  parameter int p_addr_nbits = 5,
  parameter int p_cnt_nbits  = 16
) (
  input logic             clk,
  input logic             reset,
  cmn_wb_arbiter_if.slave wb
);

  localparam logic [p_addr_nbits-1:0] ZERO_A = p_addr_nbits'(ZERO_REG_ADDR);

  logic [1:0]              gnt;
  logic                    fire;
  logic [p_addr_nbits-1:0] sel_addr;
  logic [p_data_nbits-1:0] sel_data;

  logic                    wr_en_q, wr_en_d;
  logic [p_addr_nbits-1:0] wr_addr_q, wr_addr_d;
  logic [p_data_nbits-1:0] wr_data_q, wr_data_d;
  logic [p_cnt_nbits-1:0]  stall_q, stall_d;

  cmn_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({wb.in1_val, wb.in0_val}),
    .en    (1'b1),
    .gnt   (gnt)
  );

  assign wb.in0_rdy = gnt[0];
  assign wb.in1_rdy = gnt[1];
  assign fire       = |gnt;
  assign sel_addr   = gnt[1] ? wb.in1_addr : wb.in0_addr;
  assign sel_data   = gnt[1] ? wb.in1_data : wb.in0_data;

  always_comb begin
    wr_en_d   = fire && (sel_addr != ZERO_A);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    stall_d   = stall_q;
    // An x0 write is consumed without disturbing the held address and data.
    if (wr_en_d) begin
      wr_addr_d = sel_addr;
      wr_data_d = sel_data;
    end
    if (wb.in0_val && wb.in1_val && !(&stall_q)) stall_d = stall_q + p_cnt_nbits'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      stall_q   <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      stall_q   <= stall_d;
    end
  end

  assign wb.wr_en       = wr_en_q;
  assign wb.wr_addr     = wr_addr_q;
  assign wb.wr_data     = wr_data_q;
  assign wb.stall_count = stall_q;

  // The regfile has not committed wr_* yet, so readers of that address take it from here.
  assign wb.byp_hit0  = wr_en_q && (wr_addr_q == wb.byp_addr0) && (wb.byp_addr0 != ZERO_A);
  assign wb.byp_hit1  = wr_en_q && (wr_addr_q == wb.byp_addr1) && (wb.byp_addr1 != ZERO_A);
  assign wb.byp_data0 = wb.byp_hit0 ? wr_data_q : '0;
  assign wb.byp_data1 = wb.byp_hit1 ? wr_data_q : '0;

endmodule

// File: tb/tb_cmn_wb_arbiter.sv
// Directed bench for cmn_wb_arbiter: arbitration, latency, x0 writes, forwarding, async reset and stall saturation.
module tb_cmn_wb_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  cmn_wb_arbiter_if                  wb ();
  cmn_wb_arbiter_if #(.p_cnt_nbits(2)) sif ();

  cmn_wb_arbiter u_dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb.slave)
  );

  cmn_wb_arbiter #(.p_cnt_nbits(2)) u_sat (
    .clk   (clk),
    .reset (reset),
    .wb    (sif.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb.in0_val = v; wb.in0_addr = a; wb.in0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb.in1_val = v; wb.in1_addr = a; wb.in1_data = d;
  endtask

  initial begin
    drive0(1'b1, 5'd3, 32'hDEADBEEF);
    drive1(1'b0, 5'd0, 32'h0);
    wb.byp_addr0 = 5'd0; wb.byp_addr1 = 5'd0;
    sif.in0_val = 1'b0; sif.in0_addr = 5'd1; sif.in0_data = 32'h1;
    sif.in1_val = 1'b0; sif.in1_addr = 5'd2; sif.in1_data = 32'h2;
    sif.byp_addr0 = 5'd0; sif.byp_addr1 = 5'd0;

    // Reset state, with in0 already requesting.
    tick();
    check("rst_wr_en", {31'b0, wb.wr_en}, 32'd0);
    check("rst_wr_addr", {27'b0, wb.wr_addr}, 32'd0);
    check("rst_wr_data", wb.wr_data, 32'd0);
    check("rst_stall", {16'b0, wb.stall_count}, 32'd0);
    check("rst_in0_rdy", {31'b0, wb.in0_rdy}, 32'd0);

    // Single producer, latency 1.
    reset = 1'b1;
    #1;
    check("t1_in0_rdy", {31'b0, wb.in0_rdy}, 32'd1);
    check("t1_in1_rdy", {31'b0, wb.in1_rdy}, 32'd0);
    tick();
    drive0(1'b0, 5'd3, 32'hDEADBEEF);
    #1;
    check("t1_wr_en", {31'b0, wb.wr_en}, 32'd1);
    check("t1_wr_addr", {27'b0, wb.wr_addr}, 32'd3);
    check("t1_wr_data", wb.wr_data, 32'hDEADBEEF);
    tick();
    check("t1_wr_en_off", {31'b0, wb.wr_en}, 32'd0);
    check("t1_addr_hold", {27'b0, wb.wr_addr}, 32'd3);

    // Continuous conflict: grants alternate starting from in0.
    pulse_reset();
    drive0(1'b1, 5'd1, 32'h11);
    drive1(1'b1, 5'd2, 32'h22);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_rdy0_%0d", i), {31'b0, wb.in0_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("t2_rdy1_%0d", i), {31'b0, wb.in1_rdy}, (i % 2 == 0) ? 32'd0 : 32'd1);
      tick();
      check($sformatf("t2_wr_addr_%0d", i), {27'b0, wb.wr_addr}, (i % 2 == 0) ? 32'd1 : 32'd2);
      check($sformatf("t2_wr_data_%0d", i), wb.wr_data, (i % 2 == 0) ? 32'h11 : 32'h22);
      check($sformatf("t2_stall_%0d", i), {16'b0, wb.stall_count}, i + 1);
    end
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);

    // x0 write from in1 is consumed but not written, and in0 then goes alone.
    drive1(1'b1, 5'd0, 32'h55);
    #1;
    check("t3_in1_rdy", {31'b0, wb.in1_rdy}, 32'd1);
    tick();
    drive1(1'b0, 5'd0, 32'h0);
    drive0(1'b1, 5'd4, 32'h44);
    #1;
    check("t3_x0_wr_en", {31'b0, wb.wr_en}, 32'd0);
    check("t3_stall_hold", {16'b0, wb.stall_count}, 32'd4);
    check("t3_in0_rdy", {31'b0, wb.in0_rdy}, 32'd1);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    #1;
    check("t3_wr_en", {31'b0, wb.wr_en}, 32'd1);
    check("t3_wr_addr", {27'b0, wb.wr_addr}, 32'd4);

    // Forwarding.
    drive0(1'b1, 5'd7, 32'hCAFE);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    wb.byp_addr0 = 5'd7; wb.byp_addr1 = 5'd8;
    #1;
    check("t4_hit0", {31'b0, wb.byp_hit0}, 32'd1);
    check("t4_data0", wb.byp_data0, 32'hCAFE);
    check("t4_hit1", {31'b0, wb.byp_hit1}, 32'd0);
    check("t4_data1", wb.byp_data1, 32'd0);
    wb.byp_addr0 = 5'd0; wb.byp_addr1 = 5'd7;
    #1;
    check("t4_hit0_x0", {31'b0, wb.byp_hit0}, 32'd0);
    check("t4_hit1_b", {31'b0, wb.byp_hit1}, 32'd1);

    // Async reset mid-cycle while a write is pending.
    tick();
    drive0(1'b1, 5'd9, 32'h99);
    tick();
    wb.byp_addr0 = 5'd9; wb.byp_addr1 = 5'd9;
    drive0(1'b1, 5'd1, 32'h11);
    drive1(1'b1, 5'd2, 32'h22);
    #1;
    check("t5_wr_en_pre", {31'b0, wb.wr_en}, 32'd1);
    check("t5_hit0_pre", {31'b0, wb.byp_hit0}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_wr_en_rst", {31'b0, wb.wr_en}, 32'd0);
    check("t5_rdy0_rst", {31'b0, wb.in0_rdy}, 32'd0);
    check("t5_rdy1_rst", {31'b0, wb.in1_rdy}, 32'd0);
    check("t5_hit0_rst", {31'b0, wb.byp_hit0}, 32'd0);
    check("t5_hit1_rst", {31'b0, wb.byp_hit1}, 32'd0);
    check("t5_stall_rst", {16'b0, wb.stall_count}, 32'd0);
    tick();
    reset = 1'b1;
    #1;
    check("t5_rdy0_post", {31'b0, wb.in0_rdy}, 32'd1);
    check("t5_rdy1_post", {31'b0, wb.in1_rdy}, 32'd0);
    tick();
    drive0(1'b0, 5'd0, 32'h0);
    drive1(1'b0, 5'd0, 32'h0);
    #1;
    check("t5_wr_addr_post", {27'b0, wb.wr_addr}, 32'd1);

    // Saturating 2-bit stall counter.
    sif.in0_val = 1'b1; sif.in1_val = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("t6_sat_%0d", i), {30'b0, sif.stall_count}, (i < 3) ? i + 1 : 3);
    end
    sif.in0_val = 1'b0; sif.in1_val = 1'b0;

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
